// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch / write-back stage feeding a combinational ALU.
// Reads a 32 x 32-bit register file (x0 hardwired to zero), registers the ALU
// operands and opcode, and writes the ALU result back to rd when the held
// instruction retires. A writeback-to-read bypass lets dependent instructions
// issue back-to-back without stalling.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    upstream handshake for decoded instructions
//   in_rs1, in_rs2, in_rd  register indices (rd == 0 means no writeback)
//   in_imm, in_use_imm     12-bit immediate, sign-extended when selected as source2
//   in_oper                ALU opcode, passed through unchanged
//   source1, source2, oper registered ALU operands and opcode
//   out_valid / out_ready  downstream handshake (out_ready retires the held op)
//   alu_res                combinational ALU result for the held instruction
//   dbg_addr, dbg_data     combinational register-file debug read, no bypass
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [11:0] in_imm,
    input  logic        in_use_imm,
    input  logic [2:0]  in_oper,
    output logic [31:0] source1,
    output logic [31:0] source2,
    output logic [2:0]  oper,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] alu_res,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OW   = 3;
    localparam int unsigned IMMW = 12;

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_source1;
    logic [XLEN-1:0] r_source2;
    logic [OW-1:0]   r_oper;
    logic [AW-1:0]   r_rd_q;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_retire;
    logic            w_wr_en;
    logic [XLEN-1:0] w_imm_sext;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_src2_next;

    // Handshake: a stalled held instruction blocks the upstream port.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_retire = r_out_valid && out_ready;
    assign w_wr_en  = w_retire && (r_rd_q != '0);

    assign w_imm_sext = {{(XLEN-IMMW){in_imm[IMMW-1]}}, in_imm};

    // Source 1 read with bypass of the result being written this edge.
    always_comb begin
        w_rs1_val = r_regs[in_rs1];
        if (in_rs1 == '0) begin
            w_rs1_val = '0;
        end else if (w_wr_en && (r_rd_q == in_rs1)) begin
            w_rs1_val = alu_res;
        end
    end

    // Source 2 read with the same bypass.
    always_comb begin
        w_rs2_val = r_regs[in_rs2];
        if (in_rs2 == '0) begin
            w_rs2_val = '0;
        end else if (w_wr_en && (r_rd_q == in_rs2)) begin
            w_rs2_val = alu_res;
        end
    end

    assign w_src2_next = in_use_imm ? w_imm_sext : w_rs2_val;

    // Held-stage registers; operands keep their last values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_source1   <= '0;
            r_source2   <= '0;
            r_oper      <= '0;
            r_rd_q      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_source1   <= w_rs1_val;
                r_source2   <= w_src2_next;
                r_oper      <= in_oper;
                r_rd_q      <= in_rd;
                r_out_valid <= 1'b1;
            end else if (w_retire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Register file; entry 0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[r_rd_q] <= alu_res;
        end
    end

    assign source1   = r_source1;
    assign source2   = r_source2;
    assign oper      = r_oper;
    assign out_valid = r_out_valid;
    assign dbg_data  = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by a
// random stream, checked against a scoreboard queue of expected operands and
// a reference register file.
module tb_operand_fetch;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [2:0]  op;
        logic [4:0]  rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [11:0] in_imm;
    logic        in_use_imm;
    logic [2:0]  in_oper;
    logic [31:0] source1;
    logic [31:0] source2;
    logic [2:0]  oper;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_res;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    int          n_vec;
    int          n_err;

    operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_oper    (in_oper),
        .source1    (source1),
        .source2    (source2),
        .oper       (oper),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_res    (alu_res),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b111:  return a & b;
            3'b110:  return a | b;
            3'b100:  return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rv(input logic [4:0] r, input logic ret, input logic [4:0] ret_rd,
                                       input logic [31:0] res);
        if (r == 5'd0) return 32'h0;
        if (ret && ret_rd == r) return res;
        return m_regs[r];
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [11:0] imm, input logic use_imm, input logic [2:0] op, input logic ordy);
        in_valid   = v;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_oper    = op;
        out_ready  = ordy;
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    // One clock: check outputs against the model, then advance model and DUT.
    task automatic cycle();
        logic        rdy;
        logic        acc;
        logic        ret;
        logic [4:0]  ret_rd;
        exp_t        e;
        alu_res = (q.size() != 0) ? alu(q[0].s1, q[0].s2, q[0].op) : $urandom();
        #1;
        rdy = (q.size() == 0) || out_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("source1", source1, q[0].s1);
            chk("source2", source2, q[0].s2);
            chk("oper", 32'(oper), 32'(q[0].op));
        end
        chk("dbg_data", dbg_data, (dbg_addr == 5'd0) ? 32'h0 : m_regs[dbg_addr]);
        acc    = in_valid && rdy;
        ret    = (q.size() != 0) && out_ready;
        ret_rd = (q.size() != 0) ? q[0].rd : 5'd0;
        e.s1 = rv(in_rs1, ret, ret_rd, alu_res);
        e.s2 = in_use_imm ? {{20{in_imm[11]}}, in_imm} : rv(in_rs2, ret, ret_rd, alu_res);
        e.op = in_oper;
        e.rd = in_rd;
        @(posedge clk);
        if (ret) begin
            if (ret_rd != 5'd0) m_regs[ret_rd] = alu_res;
            void'(q.pop_front());
        end
        if (acc) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic dump_regs();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 12'h0, 1'b0, 3'b000, 1'b1);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            cycle();
        end
    endtask

    task automatic chk_dbg(input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk("dbg_direct", dbg_data, exp);
    endtask

    initial begin
        logic [31:0] held_s1;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        alu_res = 32'h0;
        dbg_addr = 5'd0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 12'h0, 1'b0, 3'b000, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_source1", source1, 32'h0);
        chk("rst_source2", source2, 32'h0);
        chk("rst_oper", 32'(oper), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Immediate path and sign extension.
        drive(1'b1, 5'd0, 5'd0, 5'd1, 12'h005, 1'b1, 3'b000, 1'b1);
        cycle();
        chk("imm_source1", source1, 32'h0);
        chk("imm_source2", source2, 32'h5);
        drive(1'b1, 5'd0, 5'd0, 5'd3, 12'h800, 1'b1, 3'b000, 1'b1);
        cycle();
        chk_dbg(5'd1, 32'h5);
        chk("imm_sext", source2, 32'hFFFFF800);

        // Back-to-back bypass: x1 = 5 retires while rd=2 reads x1 twice.
        drive(1'b1, 5'd0, 5'd0, 5'd1, 12'h005, 1'b1, 3'b000, 1'b1);
        cycle();
        drive(1'b1, 5'd1, 5'd1, 5'd2, 12'h000, 1'b0, 3'b000, 1'b1);
        cycle();
        chk("byp_source1", source1, 32'h5);
        chk("byp_source2", source2, 32'h5);
        drive(1'b1, 5'd0, 5'd0, 5'd1, 12'h005, 1'b1, 3'b000, 1'b1);
        cycle();
        chk_dbg(5'd2, 32'd10);
        drive(1'b1, 5'd1, 5'd1, 5'd2, 12'h000, 1'b0, 3'b100, 1'b1);
        cycle();

        // x0 destination is discarded; later rs1 = 0 reads zero.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 12'h7FF, 1'b1, 3'b110, 1'b1);
        cycle();
        chk_dbg(5'd2, 32'h0);
        drive(1'b1, 5'd0, 5'd0, 5'd4, 12'h001, 1'b1, 3'b000, 1'b1);
        cycle();
        chk_dbg(5'd0, 32'h0);
        chk("x0_source1", source1, 32'h0);

        // Stall for 3 cycles, then retire and accept on the same edge.
        held_s1 = source1;
        drive(1'b1, 5'd4, 5'd0, 5'd5, 12'h002, 1'b1, 3'b000, 1'b0);
        dbg_addr = 5'd4;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_source1", source1, held_s1);
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        chk_dbg(5'd4, 32'h0);
        out_ready = 1'b1;
        cycle();
        chk("release_bypass", source1, 32'h1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 12'h0, 1'b0, 3'b000, 1'b1);
        cycle();
        chk_dbg(5'd5, 32'h3);

        // Reset while an instruction is held: it must be dropped.
        drive(1'b1, 5'd0, 5'd0, 5'd6, 12'h123, 1'b1, 3'b000, 1'b0);
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_source1", source1, 32'h0);
        chk("mid_rst_source2", source2, 32'h0);
        chk("mid_rst_oper", 32'(oper), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dump_regs();

        // Random stream against the model.
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 12'($urandom()), 1'($urandom_range(0, 1)),
                  3'($urandom()), 1'($urandom_range(0, 9) < 7));
            dbg_addr = 5'($urandom_range(0, 7));
            cycle();
        end
        dump_regs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch/write-back stage directly upstream of the CPU's combinational ALU. It accepts decoded instructions over a valid/ready handshake and reads a 32 x 32-bit register file with x0 hardwired to zero. It registers source1/source2/oper for the ALU, then writes the ALU result back to rd when the ALU-stage instruction retires. Writeback-to-read bypass removes all stalls for back-to-back dependent instructions.

## Interface
- No parameters. Data width is fixed at 32, register count at 32, and oper at 3 bits.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert and active-low.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_rs1  input  5  source register 1 index.
- in_rs2  input  5  source register 2 index.
- in_rd  input  5  destination register index; 0 means no writeback.
- in_imm  input  12  immediate, sign-extended to 32 bits.
- in_use_imm  input  1  1: source2 = sext(in_imm); 0: source2 = reg[rs2].
- in_oper  input  3  ALU opcode, passed through unchanged: 000 add, 111 and, 110 or, 100 xor, others give 0.
- source1  output  32  registered ALU operand 1.
- source2  output  32  registered ALU operand 2.
- oper  output  3  registered ALU opcode.
- out_valid  output  1  source1/source2/oper hold a live instruction.
- out_ready  input  1  downstream consumes the ALU result this cycle.
- alu_res  input  32  combinational ALU result for the held instruction.
- dbg_addr  input  5  debug read index.
- dbg_data  output  32  combinational reg[dbg_addr], 0 for x0; no bypass.

## Operation
- Register file: x1..x31 are flops; x0 reads 0 and ignores writes.
- Held-stage registers: source1, source2, oper, a hidden rd_q, and out_valid.
- in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at an edge.
  - Capture rd_q = in_rd and oper = in_oper.
  - source1 = rdval(in_rs1).
  - source2 = in_use_imm ? {{20{in_imm[11]}}, in_imm} : rdval(in_rs2).
- Retire: out_valid && out_ready at an edge.
  - If rd_q != 0, write reg[rd_q] = alu_res.
- rdval(r) = 0 if r == 0; else alu_res if retiring this edge with rd_q == r; else reg[r]. This is the bypass.
- out_valid next state:
  - 1 when an instruction is accepted.
  - Else 0 when retiring.
  - Else holds.
- Stall: out_valid && !out_ready.
  - in_ready = 0.
  - source1/source2/oper/rd_q stay stable.
  - No writeback.
- Simultaneous retire and accept at one edge is legal: write the old rd_q, capture the new instruction with bypass, out_valid stays 1.
- While out_valid = 0, source1/source2/oper keep their last values; the ALU input is don't-care.
- rs1 == rs2 == retiring rd: both operands take the bypassed alu_res.

## Timing
- Reset (rst_n low, any time, asynchronous):
  - out_valid = 0, source1 = 0, source2 = 0, oper = 000, rd_q = 0.
  - All registers = 0, so in_ready = 1 and dbg_data = 0.
- Reset mid-operation drops the held instruction with no writeback. An instruction offered during reset is not accepted.
- First edge after rst_n rises behaves normally.
- Latency: an instruction accepted at edge T drives source1/source2/oper with out_valid = 1 after T. Its result is written at the first edge T+k (k >= 1) where out_ready = 1.
- Throughput: one instruction per cycle with out_ready held 1; dependent instructions do not stall.
- The register write is visible on dbg_data after the retiring edge.
- in_ready and dbg_data are combinational. All other outputs are flop outputs.

## Test plan
- Reset: pulse rst_n low mid-stream with out_valid = 1.
  - Required: out_valid = 0, source1 = source2 = 0, and oper = 000 immediately.
  - Required: dbg_data = 0 for all 32 addresses, and no writeback of the dropped rd.
- Immediate path: accept rd=1, rs1=0, imm=0x005, use_imm, add with out_ready = 1.
  - Required: source1 = 0, source2 = 5; the bench drives alu_res = 5; reg1 = 5 after retire.
  - Then imm = 0x800 gives source2 = 0xFFFFF800.
- Back-to-back bypass: x1 = 5 retiring while accepting rd=2, rs1=1, rs2=1, add.
  - Required: source1 = source2 = 5 on the next cycle, then reg2 = 10.
  - Same sequence with xor gives reg2 = 0.
- x0: accept rd=0, rs1=0, imm=0x7FF, or.
  - Required: retire leaves reg0 reading 0.
  - A following instruction with rs1 = 0 gets source1 = 0, not 0x7FF.
- Stall: hold out_ready = 0 for 3 cycles with in_valid = 1.
  - Required: in_ready = 0 and outputs stable, with no register change.
  - On release: the held instruction retires and the next is accepted on the same edge.
- Random: 10k random instructions with random in_valid and out_ready against a reference model.
  - Required: all register values and every source1/source2/oper output match the model.
